// File: rtl/tff_bank_ctrl.sv
// Arbitrated write/read controller for a bank of temporal flip-flop cells.
// Writes clear then pulse WE for wr_len cycles; reads time the first fresh rising edge on cell_out.
module tff_bank_ctrl #(
  parameter int NCELL   = 4,
  parameter int AW      = 2,
  parameter int TW      = 8,
  parameter int CLR_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [TW-1:0]    wr_len,
  output logic             wr_ack,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ack,
  output logic [TW-1:0]    rd_data,
  output logic             rd_timeout,
  output logic [NCELL-1:0] cell_we,
  output logic [NCELL-1:0] cell_re,
  output logic [NCELL-1:0] cell_rstb,
  input  logic [NCELL-1:0] cell_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, WRITE, READ} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TW-1:0]     len_q, len_d;
  logic              last_wr_q, last_wr_d;
  logic              settle_q, settle_d;
  logic [NCELL-1:0]  we_q, we_d;
  logic [NCELL-1:0]  re_q, re_d;
  logic [NCELL-1:0]  rstb_q, rstb_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic [TW-1:0]     rd_data_q, rd_data_d;
  logic              rd_to_q, rd_to_d;
  logic              busy_q, busy_d;
  logic [NCELL-1:0]  sync1_q, sync1_d;
  logic [NCELL-1:0]  sync2_q, sync2_d;
  logic [NCELL-1:0]  sync3_q, sync3_d;

  logic              wr_grant;
  logic              rise;

  // Out-of-range addresses decode to all-zero, so they touch no cell.
  function automatic logic [NCELL-1:0] dec(input logic [AW-1:0] a);
    logic [NCELL-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (32'(a) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    last_wr_d = last_wr_q;
    settle_d  = 1'b0;
    we_d      = we_q;
    re_d      = re_q;
    rstb_d    = rstb_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    rd_data_d = rd_data_q;
    rd_to_d   = rd_to_q;
    sync1_d   = cell_out;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;

    wr_grant  = wr_req && (!rd_req || !last_wr_q);
    rise      = |(dec(addr_q) & sync2_q & ~sync3_q);

    case (state_q)
      IDLE: begin
        rstb_d = '1;
        we_d   = '0;
        re_d   = '0;
        // No grant in the ack cycle (requester still holds req) or the first cycle out of reset.
        if (!settle_q && !wr_ack_q && !rd_ack_q) begin
          if (wr_grant) begin
            state_d   = CLEAR;
            addr_d    = wr_addr;
            len_d     = wr_len;
            cnt_d     = '0;
            last_wr_d = 1'b1;
            rstb_d    = ~dec(wr_addr);
          end else if (rd_req) begin
            state_d   = READ;
            addr_d    = rd_addr;
            cnt_d     = '0;
            last_wr_d = 1'b0;
            re_d      = dec(rd_addr);
          end
        end
      end
      CLEAR: begin
        if (cnt_q == TW'(CLR_CYC - 1)) begin
          rstb_d = '1;
          cnt_d  = '0;
          if (len_q != '0) begin
            state_d = WRITE;
            we_d    = dec(addr_q);
          end else begin
            state_d  = IDLE;
            wr_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == len_q - TW'(1)) begin
          we_d     = '0;
          state_d  = IDLE;
          wr_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      READ: begin
        if (rise || cnt_q == '1) begin
          re_d      = '0;
          state_d   = IDLE;
          rd_ack_d  = 1'b1;
          rd_data_d = rise ? cnt_q : '1;
          rd_to_d   = !rise;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      last_wr_q <= 1'b0;
      settle_q  <= 1'b1;
      we_q      <= '0;
      re_q      <= '0;
      rstb_q    <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_to_q   <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      last_wr_q <= last_wr_d;
      settle_q  <= settle_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rstb_q    <= rstb_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      rd_to_q   <= rd_to_d;
      busy_q    <= busy_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
    end
  end

  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign rd_timeout = rd_to_q;
  assign cell_we    = we_q;
  assign cell_re    = re_q;
  assign cell_rstb  = rstb_q;
  assign busy       = busy_q;

  a_single_strobe: assert property (@(posedge clk) disable iff (rst) $onehot0(cell_we | cell_re));
  a_we_re_excl:    assert property (@(posedge clk) disable iff (rst) (cell_we & cell_re) == '0);
  a_no_io_in_clr:  assert property (@(posedge clk) disable iff (rst) ((cell_we | cell_re) & ~cell_rstb) == '0);

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Directed bench for tff_bank_ctrl: reset, tie arbitration, write, read, boundaries, mid-op reset.
module tb_tff_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_len;
  logic       wr_ack, rd_ack, rd_timeout, busy;
  logic [7:0] rd_data;
  logic [3:0] cell_we, cell_re, cell_rstb, cell_out;

  int tests = 0;
  int fails = 0;
  int n;

  tff_bank_ctrl #(.NCELL(4), .AW(2), .TW(8), .CLR_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_timeout(rd_timeout),
    .cell_we(cell_we), .cell_re(cell_re), .cell_rstb(cell_rstb), .cell_out(cell_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until the selected ack is seen or the budget expires; cnt = negedges waited.
  task automatic wait_ack(input bit is_rd, input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(is_rd ? rd_ack : wr_ack) && cnt < budget);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; cell_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rstb", cell_rstb, 4'h0);
    chk("rst_we", cell_we, 0);
    chk("rst_re", cell_re, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_timeout", rd_timeout, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstb_release", cell_rstb, 4'hF);

    // Tie after reset: write first; write re-requests, so second tie goes to read.
    wr_req = 1'b1; wr_addr = 2'd3; wr_len = 8'd1; rd_req = 1'b1; rd_addr = 2'd1;
    @(negedge clk);
    chk("tie1_rstb", cell_rstb, 4'b0111);
    chk("tie1_re", cell_re, 0);
    chk("tie1_busy", busy, 1);
    wait_ack(1'b0, 20, n);
    chk("tie1_wr_ack", wr_ack, 1);
    chk("tie1_wr_lat", n, 5);
    @(negedge clk);
    chk("tie2_idle", busy, 0);
    @(negedge clk);
    chk("tie2_read_first", cell_re, 4'b0010);
    chk("tie2_rstb", cell_rstb, 4'hF);
    cell_out[1] = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("tie2_rd_ack", rd_ack, 1);
    chk("tie2_rd_lat", n, 3);
    chk("tie2_rd_data", rd_data, 2);
    chk("tie2_timeout", rd_timeout, 0);
    rd_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("tie2_wr_ack", wr_ack, 1);
    chk("tie2_wr_lat", n, 7);
    wr_req = 1'b0; cell_out = '0;
    @(negedge clk);

    // Write addr 2, len 5.
    wr_req = 1'b1; wr_addr = 2'd2; wr_len = 8'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_rstb", cell_rstb, 4'b1011);
      chk("clr_we", cell_we, 0);
      chk("clr_busy", busy, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wr_we", cell_we, 4'b0100);
      chk("wr_rstb", cell_rstb, 4'hF);
      chk("wr_ack_early", wr_ack, 0);
    end
    @(negedge clk);
    chk("wr_ack", wr_ack, 1);
    chk("wr_busy_done", busy, 0);
    chk("wr_we_done", cell_we, 0);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", wr_ack, 0);

    // Read addr 1, edge 10 cycles after RE.
    rd_req = 1'b1; rd_addr = 2'd1;
    @(negedge clk);
    chk("rd_re", cell_re, 4'b0010);
    repeat (10) @(negedge clk);
    cell_out[1] = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("rd_ack", rd_ack, 1);
    chk("rd_data_range", 32'(rd_data >= 8'd11 && rd_data <= 8'd13), 1);
    chk("rd_timeout0", rd_timeout, 0);
    chk("rd_re_dropped", cell_re, 0);
    rd_req = 1'b0; cell_out = '0;
    @(negedge clk);
    chk("rd_ack_pulse", rd_ack, 0);

    // wr_len == 0: clear only; cell 2 high meanwhile for the next read.
    cell_out[2] = 1'b1;
    wr_req = 1'b1; wr_addr = 2'd1; wr_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_rstb", cell_rstb, 4'b1101);
      chk("len0_we", cell_we, 0);
    end
    @(negedge clk);
    chk("len0_wr_ack", wr_ack, 1);
    chk("len0_we_after", cell_we, 0);
    chk("len0_busy", busy, 0);
    wr_req = 1'b0;
    @(negedge clk);

    // Level already high at READ entry is ignored.
    rd_req = 1'b1; rd_addr = 2'd2;
    @(negedge clk);
    chk("lvl_re", cell_re, 4'b0100);
    repeat (5) begin
      @(negedge clk);
      chk("lvl_no_ack_high", rd_ack, 0);
    end
    cell_out[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lvl_no_ack_low", rd_ack, 0);
    end
    cell_out[2] = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("lvl_rd_ack", rd_ack, 1);
    chk("lvl_rd_data", rd_data, 10);
    chk("lvl_timeout", rd_timeout, 0);
    rd_req = 1'b0; cell_out = '0;
    @(negedge clk);

    // Timeout on addr 0.
    rd_req = 1'b1; rd_addr = 2'd0;
    wait_ack(1'b1, 300, n);
    chk("to_rd_ack", rd_ack, 1);
    chk("to_lat", n, 257);
    chk("to_rd_data", rd_data, 255);
    chk("to_flag", rd_timeout, 1);
    chk("to_re_dropped", cell_re, 0);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_hold_data", rd_data, 255);
    chk("to_hold_flag", rd_timeout, 1);

    // Reset during WRITE cycle 3 of 5; requester keeps wr_req high to retry.
    wr_req = 1'b1; wr_addr = 2'd2; wr_len = 8'd5;
    repeat (4) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_we", cell_we, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", cell_we, 0);
    chk("mid_rst_rstb", cell_rstb, 4'h0);
    chk("mid_rst_ack", wr_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(negedge clk);
    chk("mid_rst_ack2", wr_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rstb_release", cell_rstb, 4'hF);
    chk("mid_no_ack", wr_ack, 0);
    wait_ack(1'b0, 30, n);
    chk("retry_wr_ack", wr_ack, 1);
    chk("retry_lat", n, 10);
    wr_req = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
